dot_accumulator: RTL and testbench
==================================

# dot_accumulator

Downstream consumer of the 16x16 Wallace-tree multiplier's 32-bit product. It accepts one product per handshake beat and sums a programmable-length sequence of products into a wide accumulator, forming a dot product. It then presents the result on a valid/ready output port. It is the first clocked stage after the combinational multiplier, so the multiplier's operand source is gated by `in_ready`.

## Interface
Parameters:
- `PROD_W`, 32, product width; matches the multiplier output.
- `ACC_W`, 40, accumulator width; must be ≥ `PROD_W`+1.
- `LEN_W`, 8, width of the sequence-length field.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `len`  in  `LEN_W`  number of products per dot product; sampled on the first beat of a sequence; 0 means 2^`LEN_W`.
- `clr`  in  1  synchronous abort/clear.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block can accept a product.
- `in_prod`  in  `PROD_W`  unsigned product.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_acc`  out  `ACC_W`  accumulated sum.
- `out_ovf`  out  1  sticky: some add in this sequence carried out of `ACC_W`.
- `busy`  out  1  high while in ACCUM or HOLD.

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- **IDLE**
  - `in_ready`=1.
  - Accepted beat: `acc`←zero-extended `in_prod`, `cnt`←1, `len_q`←`len`, `ovf`←0.
  - If the target length is 1, go to HOLD; otherwise go to ACCUM.
- **ACCUM**
  - `in_ready`=1.
  - Accepted beat: `acc`←(`acc`+zext(`in_prod`)) mod 2^`ACC_W`; `ovf`←`ovf` | carry-out; `cnt`++.
  - The beat that brings `cnt` to the target length moves the FSM to HOLD.
  - Idle cycles (`in_valid`=0) leave all state unchanged.
- **HOLD**
  - `in_ready`=0; `out_valid`=1.
  - `out_acc` and `out_ovf` remain stable until `out_valid`&&`out_ready`, then go to IDLE.
- Beat accepted ⇔ `in_valid`&&`in_ready`.
- `out_acc` and `out_ovf` are driven from the `acc` and `ovf` registers in every state.
- `clr`
  - Overrides everything in the same cycle: next state IDLE, `acc`=0, `cnt`=0, `ovf`=0.
  - A beat or output handshake in that cycle is discarded.
- Target length = `len_q`==0 ? 2^`LEN_W` : `len_q`. `cnt` is `LEN_W`+1 bits wide.
- `len` changes after the first beat have no effect until the next sequence.

## Timing
- Reset values: state IDLE, `acc`=0, `cnt`=0, `len_q`=0, `ovf`=0.
- Output reset values: `in_ready`=0 while `rst_n`=0, then 1; `out_valid`=0; `out_acc`=0; `out_ovf`=0; `busy`=0.
- Latency: `out_valid` rises the cycle after the final beat is accepted.
- Throughput: one beat per cycle during a sequence. A mandatory single bubble occurs in HOLD, minimum one cycle per result.
- `in_ready` is a function of state only; there is no combinational path from `out_ready`.
- `rst_n` assertion mid-sequence clears all state immediately (asynchronous). No partial result is ever emitted.

## Structure
- Shared package `mac_pkg`:
  - state enum (IDLE/ACCUM/HOLD);
  - default `PROD_W`/`ACC_W`/`LEN_W` constants.
- One sub-module, `acc_adder`: a combinational `ACC_W`-bit adder with carry-out. It keeps the add in the same ripple-carry style as the product adder.
- Everything else (FSM, counter, registers) lives in the top module.

## Test plan
- **Basic sum:** `len`=3, beats 0xFFFE0001 ×3 back-to-back → one cycle after the third beat, `out_valid`=1, `out_acc`=0x2_FFFA_0003, `out_ovf`=0.
- **Backpressure:** same sequence, `out_ready`=0 for 5 cycles → `out_acc` stable and `in_ready`=0 throughout. The handshake on cycle 6 returns the FSM to IDLE, with `in_ready`=1 on the next cycle.
- **Overflow:** `ACC_W`=34, `len`=5, beats 0xFFFFFFFF ×5 → `out_acc`=0x0_FFFF_FFFB, `out_ovf`=1. A following `len`=1 sequence with beat 7 → `out_acc`=7, `out_ovf`=0.
- **Length edges:**
  - `len`=1, beat 0x1234 → HOLD after one beat, `out_acc`=0x1234.
  - `len`=0, 256 beats of 1 with random `in_valid` gaps → `out_acc`=256 exactly once.
- **Abort:** `len`=4, 2 beats of 10, then `clr`=1 together with `in_valid`=1 → IDLE, `acc`=0, and that beat is dropped. Next sequence `len`=2, beats 3, 4 → `out_acc`=7.
- **Async reset:** `rst_n` pulled low mid-cycle during ACCUM → `busy`, `out_valid`, `out_acc`, `out_ovf` all 0 before the next clock edge. No result is emitted after release until a full new sequence completes.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default widths for the dot-product accumulator.
package mac_pkg;

    // Controller states: waiting for a first beat, summing, presenting a result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Default widths: the product matches the 16x16 multiplier output.
    localparam int PROD_W_DEF = 32;
    localparam int ACC_W_DEF  = 40;
    localparam int LEN_W_DEF  = 8;

endpackage

// File: rtl/acc_adder.sv
// Combinational W-bit ripple-carry adder with carry-out, used for the
// accumulator update.
module acc_adder #(
    parameter int W = 40
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry;

    // Bitwise ripple: each stage feeds its carry into the next one.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns every output
        // a default first, so bit order is respected and no latch is inferred.
        sum      = '0;
        carry    = '0;
        carry[0] = 1'b0;
        for (int i = 0; i < W; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[W];
    end

endmodule

// File: rtl/dot_accumulator.sv
// Dot-product accumulator: sums a programmable number of multiplier products
// into a wide register and presents the total on a valid/ready port.
module dot_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEN_W-1:0]  len,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic              busy
);

    localparam logic [LEN_W:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] LEN_FULL = {1'b1, {LEN_W{1'b0}}};

    state_t state, next_state;

    logic [ACC_W-1:0] acc;
    logic [LEN_W:0]   cnt;
    logic [LEN_W-1:0] len_q;
    logic             ovf;

    logic             beat;
    logic             last_beat;
    logic [LEN_W-1:0] len_sel;
    logic [LEN_W:0]   target;
    logic [LEN_W:0]   cnt_next;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_b;
    logic [ACC_W-1:0] add_sum;
    logic             add_cout;

    assign beat = in_valid && in_ready;

    // Target length and count for the current beat; the first beat of a
    // sequence uses the live len input because len_q is loaded on that beat.
    always_comb begin
        len_sel   = (state == IDLE) ? len : len_q;
        target    = (len_sel == '0) ? LEN_FULL : {1'b0, len_sel};
        cnt_next  = (state == IDLE) ? CNT_ONE : cnt + CNT_ONE;
        last_beat = (cnt_next == target);
    end

    // A first beat adds onto zero, so the same adder serves both states.
    assign add_a = (state == IDLE) ? '0 : acc;
    assign add_b = {{(ACC_W-PROD_W){1'b0}}, in_prod};

    acc_adder #(
        .W (ACC_W)
    ) u_adder (
        .a    (add_a),
        .b    (add_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking '<=' so every flop samples
        // values from before the edge, independent of block ordering.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; clr overrides every transition.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (beat) next_state = last_beat ? HOLD : ACCUM;
            ACCUM:   if (beat && last_beat) next_state = HOLD;
            HOLD:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (clr) next_state = IDLE;
    end

    // Datapath registers: accumulator, beat counter, latched length, overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (beat) begin
            acc <= add_sum;
            cnt <= cnt_next;
            ovf <= (state == IDLE) ? add_cout : (ovf | add_cout);
            if (state == IDLE) len_q <= len;
        end
    end

    // Port outputs decoded from state; in_ready is held low during reset.
    always_comb begin
        in_ready  = rst_n && (state != HOLD);
        out_valid = (state == HOLD);
        busy      = (state != IDLE);
    end

    assign out_acc = acc;
    assign out_ovf = ovf;

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed self-checking bench for dot_accumulator. A 40-bit instance carries
// most scenarios; a 34-bit instance on the same inputs exercises overflow.
module tb_dot_accumulator;

    logic        clk;
    logic        rst_n;
    logic [7:0]  len;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_prod;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [39:0] out_acc;
    logic        out_ovf;
    logic        busy;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [33:0] s_out_acc;
    logic        s_out_ovf;
    logic        s_busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dot_accumulator #(.PROD_W(32), .ACC_W(40), .LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .len       (len),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    dot_accumulator #(.PROD_W(32), .ACC_W(34), .LEN_W(8)) dut34 (
        .clk       (clk),
        .rst_n     (rst_n),
        .len       (len),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_prod   (in_prod),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_acc   (s_out_acc),
        .out_ovf   (s_out_ovf),
        .busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock, then settle 1 ns past the edge before driving or sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] p);
        in_valid = 1'b1;
        in_prod  = p;
        step();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #3;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_acc !== 40'h0) $display("FAIL rst_out_acc: got %h want 0", out_acc); else pass_cnt++;
        total_cnt++; if (out_ovf !== 1'b0 || busy !== 1'b0) $display("FAIL rst_ovf_busy: got %b%b want 00", out_ovf, busy); else pass_cnt++;
        #14 rst_n = 1'b1;
        step();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_basic_sum();
        len       = 8'd3;
        out_ready = 1'b1;
        drive_beat(32'hFFFE0001);
        drive_beat(32'hFFFE0001);
        total_cnt++; if (out_valid !== 1'b0 || busy !== 1'b1) $display("FAIL basic_mid: valid=%b busy=%b want 0/1", out_valid, busy); else pass_cnt++;
        drive_beat(32'hFFFE0001);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_acc !== 40'h02_FFFA_0003) $display("FAIL basic_acc: got %h want 02fffa0003", out_acc); else pass_cnt++;
        total_cnt++; if (out_ovf !== 1'b0) $display("FAIL basic_ovf: got %b want 0", out_ovf); else pass_cnt++;
        step();
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_return: valid=%b ready=%b want 0/1", out_valid, in_ready); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        len       = 8'd3;
        out_ready = 1'b0;
        drive_beat(32'hFFFE0001);
        drive_beat(32'hFFFE0001);
        drive_beat(32'hFFFE0001);
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_acc !== 40'h02_FFFA_0003)
                $display("FAIL bp_hold_%0d: valid=%b ready=%b acc=%h want 1/0/02fffa0003", i, out_valid, in_ready, out_acc);
            else pass_cnt++;
            step();
        end
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_before_hs: got %b want 1", out_valid); else pass_cnt++;
        handshake();
        total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_after_hs: ready=%b valid=%b want 1/0", in_ready, out_valid); else pass_cnt++;
    endtask

    task automatic test_overflow();
        len       = 8'd5;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive_beat(32'hFFFFFFFF);
        total_cnt++; if (s_out_valid !== 1'b1) $display("FAIL ovf_valid: got %b want 1", s_out_valid); else pass_cnt++;
        total_cnt++; if (s_out_acc !== 34'h0_FFFF_FFFB) $display("FAIL ovf_acc34: got %h want 0fffffffb", s_out_acc); else pass_cnt++;
        total_cnt++; if (s_out_ovf !== 1'b1) $display("FAIL ovf_flag34: got %b want 1", s_out_ovf); else pass_cnt++;
        total_cnt++; if (out_acc !== 40'h04_FFFF_FFFB || out_ovf !== 1'b0) $display("FAIL ovf_wide: acc=%h ovf=%b want 04fffffffb/0", out_acc, out_ovf); else pass_cnt++;
        handshake();
        out_ready = 1'b0;
        len       = 8'd1;
        drive_beat(32'd7);
        total_cnt++; if (s_out_valid !== 1'b1 || s_out_acc !== 34'd7 || s_out_ovf !== 1'b0)
            $display("FAIL ovf_clear: valid=%b acc=%h ovf=%b want 1/7/0", s_out_valid, s_out_acc, s_out_ovf);
        else pass_cnt++;
        handshake();
    endtask

    task automatic test_len_one();
        len       = 8'd1;
        out_ready = 1'b0;
        drive_beat(32'h0000_1234);
        total_cnt++; if (out_valid !== 1'b1 || out_acc !== 40'h1234) $display("FAIL len1: valid=%b acc=%h want 1/1234", out_valid, out_acc); else pass_cnt++;
        handshake();
    endtask

    task automatic test_len_zero();
        int valid_seen;
        logic [39:0] acc_seen;
        valid_seen = 0;
        acc_seen   = '0;
        len        = 8'd0;
        out_ready  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                step();
                if (out_valid) begin valid_seen++; acc_seen = out_acc; end
            end
            drive_beat(32'd1);
            if (i == 0) len = 8'd5;  // later len changes must not shorten the sequence
            if (out_valid) begin valid_seen++; acc_seen = out_acc; end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_valid) begin valid_seen++; acc_seen = out_acc; end
        end
        total_cnt++; if (valid_seen != 1) $display("FAIL len0_count: got %0d results want 1", valid_seen); else pass_cnt++;
        total_cnt++; if (acc_seen !== 40'd256) $display("FAIL len0_acc: got %h want 100", acc_seen); else pass_cnt++;
    endtask

    task automatic test_abort();
        len       = 8'd4;
        out_ready = 1'b1;
        drive_beat(32'd10);
        drive_beat(32'd10);
        clr = 1'b1;
        drive_beat(32'd10);
        clr = 1'b0;
        total_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_acc !== 40'h0 || in_ready !== 1'b1)
            $display("FAIL abort_clear: busy=%b valid=%b acc=%h ready=%b want 0/0/0/1", busy, out_valid, out_acc, in_ready);
        else pass_cnt++;
        len = 8'd2;
        drive_beat(32'd3);
        drive_beat(32'd4);
        total_cnt++; if (out_valid !== 1'b1 || out_acc !== 40'd7) $display("FAIL abort_next: valid=%b acc=%h want 1/7", out_valid, out_acc); else pass_cnt++;
        step();
    endtask

    task automatic test_async_reset();
        len       = 8'd4;
        out_ready = 1'b1;
        drive_beat(32'd5);
        drive_beat(32'd5);
        #3 rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL arst_ctrl: busy=%b valid=%b want 0/0", busy, out_valid); else pass_cnt++;
        total_cnt++; if (out_acc !== 40'h0 || out_ovf !== 1'b0) $display("FAIL arst_data: acc=%h ovf=%b want 0/0", out_acc, out_ovf); else pass_cnt++;
        #2 rst_n = 1'b1;
        step();
        drive_beat(32'd1);
        drive_beat(32'd1);
        drive_beat(32'd1);
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL arst_no_early: got %b want 0", out_valid); else pass_cnt++;
        drive_beat(32'd1);
        total_cnt++; if (out_valid !== 1'b1 || out_acc !== 40'd4) $display("FAIL arst_full: valid=%b acc=%h want 1/4", out_valid, out_acc); else pass_cnt++;
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        len       = 8'd0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_prod   = 32'd0;
        out_ready = 1'b0;
        test_reset();
        test_basic_sum();
        test_backpressure();
        test_overflow();
        test_len_one();
        test_len_zero();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
